ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//  Execute stage. Consumes decoder outputs (aluop/alusel/operands/waddr/wr_en) through an
//  internal ID/EX pipeline register and computes the GPR write-back result. Drives
//  ex_wr_en/ex_waddr/ex_wdata, the forwarding source for the decoder in the same cycle.
//  Contains a 32-iteration restoring divider (DIV/DIVU -> HI/LO) that holds the pipe via stall_req.
// PARAMETERS
//  DIV_ITER  32  divider iterations, 1 quotient bit per cycle; fixed, not for override.
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   reset: synchronous, active-high
//  bubble_in    in   1   upstream stall: load NOP into ID/EX instead of id_* inputs
//  id_aluop     in   8   operation code from decoder
//  id_alusel    in   3   result class: 000 NOP, 001 LOGIC, 010 SHIFT, 100 ARITH
//  id_reg1      in   32  operand 1, already forwarded or immediate
//  id_reg2      in   32  operand 2, already forwarded or immediate
//  id_waddr     in   5   destination GPR
//  id_wr_en     in   1   GPR write enable
//  ex_wr_en     out  1   GPR write enable, combinational from ID/EX
//  ex_waddr     out  5   GPR address, combinational from ID/EX
//  ex_wdata     out  32  GPR write data, combinational from ID/EX
//  hilo_we      out  1   one-cycle HI/LO write strobe (divide complete)
//  hi_o         out  32  remainder
//  lo_o         out  32  quotient
//  stall_req    out  1   hold request to pipeline control, combinational
// BEHAVIOUR
//  aluop codes (8b):
//   OR 0x25, AND 0x24, XOR 0x26, NOR 0x27
//   SLL 0x7C, SRL 0x02, SRA 0x03
//   ADDU 0x21, SUBU 0x23, SLT 0x2A
//   DIV 0x1A, DIVU 0x1B
//  ID/EX register, at each rising edge, in priority order:
//   - rst: aluop=0, alusel=0, reg1=reg2=0, waddr=0, wr_en=0.
//   - stall_req=1: hold.
//   - bubble_in=1: load the NOP values.
//   - otherwise: load id_*.
//  Result mux, combinational on ID/EX:
//   - LOGIC: bitwise op.
//   - SHIFT: value=reg2, amount=reg1[4:0]; SRA sign-fills.
//   - ARITH: ADDU/SUBU wrap mod 2^32, no overflow trap. SLT = signed(reg1)<signed(reg2) ? 1 : 0.
//   - Any unlisted aluop/alusel pair: wdata=0.
//  ex_wr_en = ID/EX wr_en, forced 0 for DIV/DIVU.
//  ex_waddr = ID/EX waddr.
//  Divider FSM states: IDLE, BUSY, DONE.
//   - IDLE, ID/EX holds DIV/DIVU: if reg2==0 -> DONE; else -> BUSY.
//     On entry to BUSY: latch |reg1|, |reg2| (DIV) or raw (DIVU) and sign flags; cnt=0.
//   - BUSY: one restoring step per cycle; cnt++. cnt==31 step -> DONE.
//   - DONE: hilo_we=1 for exactly this cycle -> IDLE.
//  DIV sign fix: quotient negated if operand signs differ; remainder takes dividend's sign.
//  Divide by zero (both ops): lo_o=32'hFFFFFFFF, hi_o=reg1. No trap.
//  stall_req = ID/EX is DIV/DIVU && state!=DONE.
//  The ID/EX register advances on the DONE edge, so a back-to-back divide restarts from IDLE.
//  Latency:
//   - ALU ops: 0 cycles (combinational).
//   - Nonzero divide: 34 cycles in stage (1 IDLE + 32 BUSY + 1 DONE); stall_req high 33 cycles.
//   - Divide by zero: 2 cycles; stall_req high 1 cycle.
//  hi_o/lo_o registered, reset 0, valid while hilo_we=1 and held afterwards.
//  Reset values: all outputs 0, state IDLE, cnt 0.
//  rst mid-divide: abort, no hilo_we, pipe resumes with NOP.
//  bubble_in while stall_req=1: ignored; hold has priority.
// TESTING
//  - ORI-style: alusel=001, aluop=0x25, reg1=0x1100, reg2=0x0011, waddr=3, wr_en=1
//    -> same cycle after load: ex_wdata=0x1111, ex_waddr=3, ex_wr_en=1.
//  - SRA reg2=0x80000000, reg1=4 -> 0xF8000000.
//    SUBU 0 - 1 -> 0xFFFFFFFF.
//    SLT 0xFFFFFFFF vs 1 -> 1.
//  - DIVU 100/7 -> stall_req high 33 cycles, hilo_we 1 cycle at cycle 34: lo=14, hi=2;
//    ex_wr_en=0 throughout.
//  - DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//    DIVU 5/0 -> stall 1 cycle, lo=0xFFFFFFFF, hi=5.
//  - rst asserted at BUSY cnt=10 -> next cycle: state IDLE, stall_req=0, no hilo_we, ID/EX NOP.
//  - bubble_in=1 with ADDU on id_* -> ex_wr_en=0, ex_wdata=0.
//    Back-to-back DIVU pair -> two separate 34-cycle sequences, two hilo_we pulses.

Source files
------------

// File: rtl/ex_stage_if.sv
// Signal bundle between the decode stage and the execute stage.
// Decode side drives the master modport; ex_stage binds to the slave modport.
interface ex_stage_if;
  // No valid/ready pair: every cycle carries an instruction or a NOP.
  // While stall_req=1 the stage holds its ID/EX register and ignores the id_* signals and bubble_in.
  // Once stall_req drops, the id_* values on the next rising edge are consumed.
  logic        bubble_in;
  logic [7:0]  id_aluop;
  logic [2:0]  id_alusel;
  logic [31:0] id_reg1;
  logic [31:0] id_reg2;
  logic [4:0]  id_waddr;
  logic        id_wr_en;
  logic        ex_wr_en;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stall_req;
  logic [1:0]  div_state;

  modport master (
    output bubble_in, id_aluop, id_alusel, id_reg1, id_reg2, id_waddr, id_wr_en,
    input  ex_wr_en, ex_waddr, ex_wdata, hilo_we, hi_o, lo_o, stall_req, div_state
  );

  modport slave (
    input  bubble_in, id_aluop, id_alusel, id_reg1, id_reg2, id_waddr, id_wr_en,
    output ex_wr_en, ex_waddr, ex_wdata, hilo_we, hi_o, lo_o, stall_req, div_state
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, combinational ALU result mux and a
// 32-step restoring divider writing HI/LO while holding the pipe.
module ex_stage (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  bus
);
  localparam int DIV_ITER = 32;
  localparam logic [4:0] LAST_STEP = 5'(DIV_ITER - 1);

  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  logic [7:0]  aluop_q;
  logic [2:0]  alusel_q;
  logic [31:0] reg1_q;
  logic [31:0] reg2_q;
  logic [4:0]  waddr_q;
  logic        wr_en_q;

  div_state_t  state;
  div_state_t  state_next;
  logic [4:0]  cnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dsr;
  logic        neg_quo;
  logic        neg_rem;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_div;
  logic        is_signed_div;
  logic        stall;
  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic [31:0] quo_step;
  logic [31:0] rem_step;
  logic [31:0] result;

  assign is_div        = (aluop_q == OP_DIV) || (aluop_q == OP_DIVU);
  assign is_signed_div = (aluop_q == OP_DIV);
  assign stall         = is_div && (state != S_DONE);

  // ID/EX register: reset, then hold on stall, then bubble, then load.
  always_ff @(posedge clk) begin
    if (rst || (!stall && bus.bubble_in)) begin
      aluop_q  <= '0;
      alusel_q <= '0;
      reg1_q   <= '0;
      reg2_q   <= '0;
      waddr_q  <= '0;
      wr_en_q  <= 1'b0;
    end else if (!stall) begin
      aluop_q  <= bus.id_aluop;
      alusel_q <= bus.id_alusel;
      reg1_q   <= bus.id_reg1;
      reg2_q   <= bus.id_reg2;
      waddr_q  <= bus.id_waddr;
      wr_en_q  <= bus.id_wr_en;
    end
  end

  always_comb begin
    result = '0;
    case (alusel_q)
      SEL_LOGIC: begin
        case (aluop_q)
          OP_OR:   result = reg1_q | reg2_q;
          OP_AND:  result = reg1_q & reg2_q;
          OP_XOR:  result = reg1_q ^ reg2_q;
          OP_NOR:  result = ~(reg1_q | reg2_q);
          default: result = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_q)
          OP_SLL:  result = reg2_q << reg1_q[4:0];
          OP_SRL:  result = reg2_q >> reg1_q[4:0];
          OP_SRA:  result = $unsigned($signed(reg2_q) >>> reg1_q[4:0]);
          default: result = '0;
        endcase
      end
      SEL_ARITH: begin
        case (aluop_q)
          OP_ADDU: result = reg1_q + reg2_q;
          OP_SUBU: result = reg1_q - reg2_q;
          OP_SLT:  result = {31'd0, ($signed(reg1_q) < $signed(reg2_q))};
          default: result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  assign bus.ex_wr_en  = wr_en_q && !is_div;
  assign bus.ex_waddr  = waddr_q;
  assign bus.ex_wdata  = result;
  assign bus.stall_req = stall;
  assign bus.hilo_we   = (state == S_DONE);
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;
  assign bus.div_state = state;

  // Signed divide runs on magnitudes; signs are reapplied on the final step.
  assign dividend_abs = (is_signed_div && reg1_q[31]) ? (~reg1_q + 32'd1) : reg1_q;
  assign divisor_abs  = (is_signed_div && reg2_q[31]) ? (~reg2_q + 32'd1) : reg2_q;

  always_comb begin
    rem_shift = {rem, quo[31]};
    diff      = rem_shift - {1'b0, dsr};
    if (!diff[32]) begin
      rem_step = diff[31:0];
      quo_step = {quo[30:0], 1'b1};
    end else begin
      rem_step = rem_shift[31:0];
      quo_step = {quo[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (is_div) state_next = (reg2_q == 32'd0) ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt == LAST_STEP) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dsr     <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_div) begin
            if (reg2_q == 32'd0) begin
              lo_q <= 32'hFFFF_FFFF;
              hi_q <= reg1_q;
            end else begin
              quo     <= dividend_abs;
              rem     <= '0;
              dsr     <= divisor_abs;
              neg_quo <= is_signed_div && (reg1_q[31] ^ reg2_q[31]);
              neg_rem <= is_signed_div && reg1_q[31];
              cnt     <= '0;
            end
          end
        end
        S_BUSY: begin
          quo <= quo_step;
          rem <= rem_step;
          cnt <= cnt + 5'd1;
          if (cnt == LAST_STEP) begin
            lo_q <= neg_quo ? (~quo_step + 32'd1) : quo_step;
            hi_q <= neg_rem ? (~rem_step + 32'd1) : rem_step;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
